// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with lock-up recovery and period measurement
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 'hB8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period_len,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] period_len_q, period_len_d;
  logic             period_valid_q, period_valid_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;

  always_comb begin
    if (MODE == 0) begin
      nxt = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end else begin
      nxt = {state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & TAPS);
    end
  end

  assign load_val = (seed_in == '0) ? SEED_EFF : seed_in;

  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    step_cnt_d     = step_cnt_q;
    period_len_d   = period_len_q;
    period_valid_d = period_valid_q;
    wrap_d         = 1'b0;
    lockup_d       = 1'b0;
    if (load) begin
      state_d        = load_val;
      ref_d          = load_val;
      step_cnt_d     = '0;
      period_valid_d = 1'b0;
    end else if (state_q == '0) begin
      // Zero is a fixed point of any LFSR; restart from the measurement reference.
      state_d    = ref_q;
      step_cnt_d = '0;
      lockup_d   = 1'b1;
    end else if (en) begin
      state_d = nxt;
      if (nxt == ref_q) begin
        wrap_d         = 1'b1;
        period_len_d   = step_cnt_q + ONE;
        period_valid_d = 1'b1;
        step_cnt_d     = '0;
      end else if (step_cnt_q != '1) begin
        step_cnt_d = step_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SEED_EFF;
      ref_q          <= SEED_EFF;
      step_cnt_q     <= '0;
      period_len_q   <= '0;
      period_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
      lockup_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      step_cnt_q     <= step_cnt_d;
      period_len_q   <= period_len_d;
      period_valid_q <= period_valid_d;
      wrap_q         <= wrap_d;
      lockup_q       <= lockup_d;
    end
  end

  assign data_out     = state_q;
  assign bit_out      = state_q[WIDTH-1];
  assign wrap         = wrap_q;
  assign lockup       = lockup_q;
  assign period_len   = period_len_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed bench for lfsr_gen in Fibonacci, Galois and lock-up configurations
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [3:0] seed_in;

  logic [3:0] fib_data, fib_plen;
  logic       fib_bit, fib_wrap, fib_lock, fib_pv;
  logic [3:0] gal_data, gal_plen;
  logic       gal_bit, gal_wrap, gal_lock, gal_pv;
  logic [3:0] zro_data, zro_plen;
  logic       zro_bit, zro_wrap, zro_lock, zro_pv;

  int checks = 0;
  int errors = 0;
  int wraps;
  int idx;

  // Maximal sequences from state 1, hand-derived.
  int fib_seq[15] = '{'h1, 'h2, 'h4, 'h9, 'h3, 'h6, 'hD, 'hA, 'h5, 'hB, 'h7, 'hF, 'hE, 'hC, 'h8};
  int gal_seq[15] = '{'h1, 'h2, 'h4, 'h8, 'h3, 'h6, 'hC, 'hB, 'h5, 'hA, 'h7, 'hE, 'hF, 'hD, 'h9};
  int zro_seq[6]  = '{'h2, 'h4, 'h8, 'h0, 'h1, 'h2};

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(0), .SEED(4'h1)) u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .data_out(fib_data), .bit_out(fib_bit), .wrap(fib_wrap), .lockup(fib_lock),
    .period_len(fib_plen), .period_valid(fib_pv)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .MODE(1), .SEED(4'h1)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .data_out(gal_data), .bit_out(gal_bit), .wrap(gal_wrap), .lockup(gal_lock),
    .period_len(gal_plen), .period_valid(gal_pv)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .MODE(1), .SEED(4'h1)) u_zro (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .data_out(zro_data), .bit_out(zro_bit), .wrap(zro_wrap), .lockup(zro_lock),
    .period_len(zro_plen), .period_valid(zro_pv)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'h0;
    tick();
    rst = 1'b0;
    check("rst_data", int'(fib_data), 1);
    check("rst_wrap", int'(fib_wrap), 0);
    check("rst_lock", int'(fib_lock), 0);
    check("rst_plen", int'(fib_plen), 0);
    check("rst_pv", int'(fib_pv), 0);
    check("rst_bit", int'(fib_bit), 0);

    // Fibonacci and Galois full periods; zero-tap lock-up runs alongside.
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("fib_seq", int'(fib_data), fib_seq[(i + 1) % 15]);
      check("fib_wrap", int'(fib_wrap), (i == 14) ? 1 : 0);
      check("fib_bit", int'(fib_bit), (fib_seq[(i + 1) % 15] >> 3) & 1);
      check("gal_seq", int'(gal_data), gal_seq[(i + 1) % 15]);
      check("gal_wrap", int'(gal_wrap), (i == 14) ? 1 : 0);
      if (i < 6) begin
        check("zro_seq", int'(zro_data), zro_seq[i]);
        check("zro_lock", int'(zro_lock), (i == 4) ? 1 : 0);
        check("zro_wrap", int'(zro_wrap), 0);
        check("zro_pv", int'(zro_pv), 0);
      end
    end
    check("fib_plen", int'(fib_plen), 15);
    check("fib_pv", int'(fib_pv), 1);
    check("gal_plen", int'(gal_plen), 15);
    check("gal_pv", int'(gal_pv), 1);

    wraps = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (fib_wrap) wraps++;
      if (i == 14) check("fib_wrap2", int'(fib_wrap), 1);
    end
    check("fib_wrap_count", wraps, 1);

    // Load with en held: load wins, no step.
    for (int i = 0; i < 5; i++) tick();
    check("pre_load", int'(fib_data), 'h6);
    load = 1'b1; seed_in = 4'hA;
    tick();
    load = 1'b0;
    check("load_data", int'(fib_data), 'hA);
    check("load_pv", int'(fib_pv), 0);
    check("load_plen", int'(fib_plen), 15);
    check("load_wrap", int'(fib_wrap), 0);
    idx = 7;
    wraps = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      idx = (idx + 1) % 15;
      check("a_seq", int'(fib_data), fib_seq[idx]);
      if (fib_wrap) wraps++;
    end
    check("a_wrap_last", int'(fib_wrap), 1);
    check("a_wrap_count", wraps, 1);
    check("a_plen", int'(fib_plen), 15);
    check("a_pv", int'(fib_pv), 1);

    // Zero seed substitutes SEED.
    en = 1'b0; load = 1'b1; seed_in = 4'h0;
    tick();
    load = 1'b0;
    check("zload_data", int'(fib_data), 1);
    check("zload_pv", int'(fib_pv), 0);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("z_wrap", int'(fib_wrap), (i == 14) ? 1 : 0);
    end
    check("z_data", int'(fib_data), 1);
    check("z_plen", int'(fib_plen), 15);

    // Hold mid-run, then resume.
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_data", int'(fib_data), 'h9);
      check("hold_wrap", int'(fib_wrap), 0);
      check("hold_lock", int'(fib_lock), 0);
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("resume_wrap", int'(fib_wrap), (i == 11) ? 1 : 0);
    end
    check("resume_plen", int'(fib_plen), 15);
    check("resume_pv", int'(fib_pv), 1);

    // Reset mid-run discards the measurement.
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_data", int'(fib_data), 1);
    check("mrst_pv", int'(fib_pv), 0);
    check("mrst_plen", int'(fib_plen), 0);
    check("mrst_wrap", int'(fib_wrap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised LFSR pseudo-random generator, successor to the fixed 4/7-bit shift-left LFSRs. It provides the following:
- Configurable width, tap mask, seed and topology (Fibonacci or Galois).
- Runtime seed load and step enable.
- All-zero lock-up detection with automatic recovery.
- Period measurement: the number of steps taken to return to the start state.

It feeds test-pattern, scrambler and BIST datapaths.

Parameters:
WIDTH, 8, state width in bits (legal range 3..32).
TAPS, 8'hB8, feedback mask of WIDTH bits. Meaning depends on MODE.
MODE, 0, topology: 0 = Fibonacci, 1 = Galois.
SEED, 1, reset/fallback state of WIDTH bits. A value of 0 is illegal; the implementation substitutes 1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
en  in  1  advance one step this cycle
load  in  1  load seed_in this cycle
seed_in  in  WIDTH  seed value for load
data_out  out  WIDTH  current state, registered
bit_out  out  1  data_out[WIDTH-1], combinational from state
wrap  out  1  one-cycle pulse: data_out has just returned to ref
lockup  out  1  one-cycle pulse: zero state was detected and replaced
period_len  out  WIDTH  last measured period
period_valid  out  1  period_len holds a valid measurement since the last load/reset

Behaviour:
- Clocking: one clock (clk); reset rst is synchronous and active-high. All outputs except bit_out are registered.
- Internal registers:
  - state (drives data_out).
  - ref: the start state for period measurement.
  - step_cnt: WIDTH bits, saturating.
- Next-state function, Fibonacci (MODE=0):
  - nxt = {state[WIDTH-2:0], ^(state & TAPS)}.
  - Example: WIDTH=4, TAPS=4'b1100 gives feedback state[3]^state[2].
- Next-state function, Galois (MODE=1):
  - nxt = {state[WIDTH-2:0],1'b0} ^ ({WIDTH{state[WIDTH-1]}} & TAPS).
- Per-edge priority: rst > load > lock-up recovery > en step > hold.
- rst:
  - state = ref = SEED.
  - step_cnt = 0, period_len = 0.
  - period_valid = 0, wrap = 0, lockup = 0.
- load (en ignored):
  - state = ref = (seed_in==0 ? SEED : seed_in).
  - step_cnt = 0, period_valid = 0, wrap = 0, lockup = 0.
  - period_len holds its previous value.
- Lock-up (state==0, no load); reachable only with non-primitive masks:
  - state = ref, step_cnt = 0, lockup = 1 for one cycle.
  - Recovery happens regardless of en.
  - No wrap is generated.
- en step (state!=0, no load):
  - state = nxt.
  - If nxt==ref: wrap = 1, period_len = step_cnt+1, period_valid = 1, step_cnt = 0.
  - Otherwise: step_cnt = step_cnt+1, saturating at 2^WIDTH-1. A saturated count means no return has occurred yet (non-invertible mask); no wrap is produced.
- Hold (en=0): state, step_cnt, period_len and period_valid hold; wrap = 0, lockup = 0.
- Latency:
  - data_out reflects a step one cycle after the enabled edge.
  - wrap/lockup are high in the same cycle that data_out shows the new state.
- wrap is never asserted on a load or reset edge, even though data_out==ref in that cycle.
- Simultaneous load+en: load wins and no step occurs.
- Reset mid-run discards any measurement in progress.
- Maximal-length masks give period 2^WIDTH-1, which fits in period_len without overflow.

Test Plan:
1. WIDTH=4, TAPS=4'b1100, MODE=0, SEED=1; rst then en=1 held.
   - Required: data_out = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
   - wrap high exactly on the 15th step; period_len=15, period_valid=1; next wrap 15 steps later.
2. WIDTH=4, TAPS=4'b0011, MODE=1, SEED=1; en=1 held.
   - Required: data_out = 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1.
   - wrap on the 15th step; period_len=15.
3. Config from 1; after 5 steps assert load with seed_in=4'hA and en=1 together.
   - Required: data_out=A next cycle, period_valid=0, no step taken.
   - Then 5,B,7,... and wrap when A recurs after 15 steps; period_len=15.
4. Config from 1; load with seed_in=0.
   - Required: data_out=1 (SEED substituted); period restarts from 1.
5. MODE=1, TAPS=4'b0000, SEED=1; en=1.
   - Required: data_out = 1,2,4,8,0.
   - Next edge: data_out=1 with lockup=1 for one cycle; wrap stays 0; period_valid stays 0.
6. Config from 1; run 3 steps, drop en for 4 cycles, then resume.
   - Required: data_out holds at 9 and wrap/lockup stay 0 while en=0; period_len=15 still measured correctly.
   - Then assert rst mid-run: data_out=1, period_valid=0, period_len=0.
